// File: rtl/rv_muldiv_p_pkg.sv
// Shared types and parameter legality helper for the RISC-V M-extension unit.
package pkg_rv_muldiv;

  // Operation code, identical to the RISC-V funct3 encoding of the M extension.
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_t;

  // Divider sequencing states.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_t;

  localparam int MUL_LAT_MIN = 1;
  localparam int MUL_LAT_MAX = 3;

  // True when the parameter set is one the datapath is built for.
  function automatic bit params_legal(input int xlen, input int div_bits, input int mul_lat);
    bit ok;
    ok = (xlen == 32) || (xlen == 64);
    ok = ok && ((div_bits == 1) || (div_bits == 2) || (div_bits == 4));
    ok = ok && ((xlen % div_bits) == 0);
    ok = ok && (mul_lat >= MUL_LAT_MIN) && (mul_lat <= MUL_LAT_MAX);
    return ok;
  endfunction

endpackage

// File: rtl/rv_div_iter.sv
// Restoring iterative divider on unsigned magnitudes, DIV_BITS quotient bits per cycle.
module rv_div_iter #(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            kill,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  localparam int NITER = XLEN / DIV_BITS;
  localparam int CW    = $clog2(NITER);

  logic            active_q, active_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;

  // DIV_BITS chained shift/trial-subtract steps; quo_q shifts dividend bits out and quotient bits in.
  always_comb begin
    logic [XLEN:0] r_sh;
    logic [XLEN:0] diff;
    rem_step = rem_q;
    quo_step = quo_q;
    r_sh     = '0;
    diff     = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      r_sh     = {rem_step, quo_step[XLEN-1]};
      diff     = r_sh - {1'b0, dsr_q};
      quo_step = {quo_step[XLEN-2:0], ~diff[XLEN]};
      rem_step = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
    end
  end

  // Load on start, iterate while active, stop after the last iteration or on kill.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    if (kill) begin
      active_d = 1'b0;
    end else if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      rem_d    = '0;
      quo_d    = dividend;
      dsr_d    = divisor;
    end else if (active_q) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(NITER - 1)) begin
        active_d = 1'b0;
      end
    end
  end

  // Only the activity flag needs reset; the datapath is qualified by it.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
    end else begin
      active_q <= active_d;
    end
    cnt_q <= cnt_d;
    rem_q <= rem_d;
    quo_q <= quo_d;
    dsr_q <= dsr_d;
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  // High during the final iteration cycle; results are valid from the next cycle on.
  assign done      = active_q && (cnt_q == CW'(NITER - 1));

endmodule

// File: rtl/rv_muldiv_p.sv
// RISC-V M-extension unit: pipelined multiplier plus iterative divider, in-order results.
module rv_muldiv_p
  import pkg_rv_muldiv::*;
#(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 2,
  parameter int MUL_LAT  = 2,
  parameter int TAGW     = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  md_op_t          op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [TAGW-1:0] req_tag,
  input  logic            kill,
  output logic            busy,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic [TAGW-1:0] rsp_tag
);

  if (!params_legal(XLEN, DIV_BITS, MUL_LAT)) begin : g_bad_params
    $error("rv_muldiv_p: illegal XLEN/DIV_BITS/MUL_LAT combination");
  end

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Request decode
  logic accept;
  logic is_div_op;
  logic div_signed;
  logic div_is_rem;
  logic div_zero;
  logic div_ovf;
  logic div_special;
  logic to_mul_pipe;
  logic div_start;
  logic rs1_neg;
  logic rs2_neg;
  logic [XLEN-1:0] rs1_mag;
  logic [XLEN-1:0] rs2_mag;

  // Multiplier
  logic signed [XLEN:0]     mul_a;
  logic signed [XLEN:0]     mul_b;
  logic signed [2*XLEN+1:0] mul_full;
  logic [XLEN-1:0]          mul_res;
  logic [XLEN-1:0]          slot_data;

  // Multiply / special-case result pipeline; entry MUL_LAT-1 drives the response
  logic [MUL_LAT-1:0]           mv_q, mv_d;
  logic [MUL_LAT-1:0][XLEN-1:0] md_q, md_d;
  logic [MUL_LAT-1:0][TAGW-1:0] mt_q, mt_d;

  // Divider control and response registers
  div_state_t      state_q, state_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            rem_sel_q, rem_sel_d;
  logic [TAGW-1:0] dtag_q, dtag_d;
  logic            drsp_valid_q, drsp_valid_d;
  logic [XLEN-1:0] drsp_data_q, drsp_data_d;
  logic [TAGW-1:0] drsp_tag_q, drsp_tag_d;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] div_rem;
  logic            div_done;

  assign req_ready = (state_q == DIV_IDLE) && !reset;
  assign accept    = req_valid && req_ready && !kill;
  assign busy      = (state_q == DIV_CALC) || (state_q == DIV_FIX);

  assign is_div_op   = (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
  assign div_signed  = (op == MD_DIV) || (op == MD_REM);
  assign div_is_rem  = (op == MD_REM) || (op == MD_REMU);
  assign div_zero    = (rs2 == '0);
  assign div_ovf     = div_signed && (rs1 == MOST_NEG) && (rs2 == '1);
  assign div_special = is_div_op && (div_zero || div_ovf);
  // Special divides take the fixed-latency slot so the divider never sees them.
  assign to_mul_pipe = accept && (!is_div_op || div_special);
  assign div_start   = accept && is_div_op && !div_special;

  assign rs1_neg = div_signed && rs1[XLEN-1];
  assign rs2_neg = div_signed && rs2[XLEN-1];
  assign rs1_mag = rs1_neg ? -rs1 : rs1;
  assign rs2_mag = rs2_neg ? -rs2 : rs2;

  // One extra bit per operand lets a single signed multiply cover all four flavours.
  always_comb begin
    mul_a    = {((op == MD_MULH) || (op == MD_MULHSU)) && rs1[XLEN-1], rs1};
    mul_b    = {(op == MD_MULH) && rs2[XLEN-1], rs2};
    mul_full = (2*XLEN+2)'(mul_a) * (2*XLEN+2)'(mul_b);
    mul_res  = (op == MD_MUL) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    if (div_special) begin
      if (div_zero) begin
        slot_data = div_is_rem ? rs1 : '1;
      end else begin
        slot_data = div_is_rem ? '0 : rs1;
      end
    end else begin
      slot_data = mul_res;
    end
  end

  // Shift the multiply slot along; kill drops everything in flight.
  always_comb begin
    mv_d    = '0;
    md_d    = md_q;
    mt_d    = mt_q;
    mv_d[0] = to_mul_pipe;
    md_d[0] = slot_data;
    mt_d[0] = req_tag;
    for (int i = 1; i < MUL_LAT; i++) begin
      mv_d[i] = mv_q[i-1];
      md_d[i] = md_q[i-1];
      mt_d[i] = mt_q[i-1];
    end
    if (kill) begin
      mv_d = '0;
    end
  end

  // Divider sequencing: IDLE -> CALC until the last iteration -> FIX for the sign correction.
  always_comb begin
    state_d      = state_q;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    rem_sel_d    = rem_sel_q;
    dtag_d       = dtag_q;
    drsp_valid_d = 1'b0;
    drsp_data_d  = rem_sel_q ? (neg_rem_q ? -div_rem : div_rem)
                             : (neg_quo_q ? -div_quo : div_quo);
    drsp_tag_d   = dtag_q;
    case (state_q)
      DIV_IDLE: begin
        if (div_start) begin
          state_d   = DIV_CALC;
          neg_quo_d = rs1_neg ^ rs2_neg;
          neg_rem_d = rs1_neg;
          rem_sel_d = div_is_rem;
          dtag_d    = req_tag;
        end
      end
      DIV_CALC: begin
        if (div_done) begin
          state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        state_d      = DIV_IDLE;
        drsp_valid_d = 1'b1;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
    if (kill) begin
      state_d      = DIV_IDLE;
      drsp_valid_d = 1'b0;
    end
  end

  // Control state and valids reset; data registers only ever qualified by valids.
  always_ff @(posedge clk) begin
    if (reset) begin
      mv_q         <= '0;
      state_q      <= DIV_IDLE;
      drsp_valid_q <= 1'b0;
    end else begin
      mv_q         <= mv_d;
      state_q      <= state_d;
      drsp_valid_q <= drsp_valid_d;
    end
    md_q        <= md_d;
    mt_q        <= mt_d;
    neg_quo_q   <= neg_quo_d;
    neg_rem_q   <= neg_rem_d;
    rem_sel_q   <= rem_sel_d;
    dtag_q      <= dtag_d;
    drsp_data_q <= drsp_data_d;
    drsp_tag_q  <= drsp_tag_d;
  end

  rv_div_iter #(
    .XLEN     (XLEN),
    .DIV_BITS (DIV_BITS)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .kill      (kill),
    .start     (div_start),
    .dividend  (rs1_mag),
    .divisor   (rs2_mag),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // A multiply and a divide result can never land in the same cycle, so a plain select suffices.
  assign rsp_valid = mv_q[MUL_LAT-1] || drsp_valid_q;
  assign rsp_data  = drsp_valid_q ? drsp_data_q : md_q[MUL_LAT-1];
  assign rsp_tag   = drsp_valid_q ? drsp_tag_q : mt_q[MUL_LAT-1];

endmodule

// File: tb/tb_rv_muldiv_p.sv
// Randomized plus directed bench for rv_muldiv_p against an arithmetic reference model.
module tb_rv_muldiv_p;
  import pkg_rv_muldiv::*;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32 / 2 + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  md_op_t      op;
  logic [31:0] rs1, rs2;
  logic [4:0]  req_tag;
  logic        kill;
  logic        busy;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_tag;

  logic        req_valid64;
  logic        req_ready64;
  md_op_t      op64;
  logic [63:0] a64, b64;
  logic [4:0]  tag64;
  logic        kill64;
  logic        busy64;
  logic        rsp_valid64;
  logic [63:0] rsp_data64;
  logic [4:0]  rsp_tag64;

  always #5 clk = ~clk;

  rv_muldiv_p dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .op(op),
    .rs1(rs1), .rs2(rs2), .req_tag(req_tag), .kill(kill), .busy(busy),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag)
  );

  rv_muldiv_p #(.XLEN(64), .DIV_BITS(4)) dut64 (
    .clk(clk), .reset(reset), .req_valid(req_valid64), .req_ready(req_ready64), .op(op64),
    .rs1(a64), .rs2(b64), .req_tag(tag64), .kill(kill64), .busy(busy64),
    .rsp_valid(rsp_valid64), .rsp_data(rsp_data64), .rsp_tag(rsp_tag64)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   div_free = 0;
  int   div_acc = -100;
  int   n_acc = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // RISC-V M semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_result(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (o)
      MD_MUL:    begin p = ua * ub; r = p[31:0]; end
      MD_MULH:   begin p = sa * sb; r = p[63:32]; end
      MD_MULHSU: begin p = sa * longint'(ub); r = p[63:32]; end
      MD_MULHU:  begin p = ua * ub; r = p[63:32]; end
      MD_DIV: begin
        if (b == 0) r = '1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      MD_DIVU: begin
        if (b == 0) r = '1;
        else begin p = ua / ub; r = p[31:0]; end
      end
      MD_REM: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 0) r = a;
        else begin p = ua % ub; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  // One clock: check outputs mid-cycle against the model, log acceptance, advance.
  task automatic tick(input bit use_exp = 1'b0, input logic [31:0] exp_val = '0);
    bit   exp_v;
    bit   is_div;
    bit   special;
    exp_t e;
    @(negedge clk);
    if (reset) begin
      check("rst_req_ready", {63'd0, req_ready}, 64'd0);
      check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
    end else begin
      check("req_ready", {63'd0, req_ready}, {63'd0, cyc >= div_free});
      check("busy", {63'd0, busy}, {63'd0, (cyc > div_acc) && (cyc < div_free)});
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_v});
      if (exp_v) begin
        if (rsp_valid) begin
          check("rsp_data", {32'd0, rsp_data}, {32'd0, exp_q[0].data});
          check("rsp_tag", {59'd0, rsp_tag}, {59'd0, exp_q[0].tag});
          $display("rsp cyc=%0d tag=%0d data=%08h", cyc, rsp_tag, rsp_data);
        end
        void'(exp_q.pop_front());
      end
      if (kill) begin
        exp_q.delete();
        if (div_free > cyc + 1) div_free = cyc + 1;
      end else if (req_valid && (cyc >= div_free)) begin
        is_div  = (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
        special = is_div && ((rs2 == 0) ||
                  (((op == MD_DIV) || (op == MD_REM)) && rs1 == 32'h8000_0000 && rs2 == 32'hFFFF_FFFF));
        e.data  = use_exp ? exp_val : ref_result(op, rs1, rs2);
        e.tag   = req_tag;
        e.due   = cyc + ((is_div && !special) ? DIV_LAT : MUL_LAT);
        exp_q.push_back(e);
        n_acc++;
        if (is_div && !special) begin
          div_acc  = cyc;
          div_free = cyc + DIV_LAT;
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input md_op_t o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    req_valid = 1'b1;
    op        = o;
    rs1       = a;
    rs2       = b;
    req_tag   = t;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(15));
      4: return -32'($urandom_range(15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          start_cyc;
    int          n_start;
    bit          seen;
    reset       = 1'b1;
    req_valid   = 1'b0;
    op          = MD_MUL;
    rs1         = '0;
    rs2         = '0;
    req_tag     = '0;
    kill        = 1'b0;
    req_valid64 = 1'b0;
    op64        = MD_MUL;
    a64         = '0;
    b64         = '0;
    tag64       = '0;
    kill64      = 1'b0;

    repeat (3) tick();
    reset = 1'b0;
    idle(2);

    // Back-to-back multiplies, one response per cycle.
    issue(MD_MULH, 32'h8000_0000, 32'h8000_0000, 5'd1);   tick(1'b1, 32'h4000_0000);
    issue(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2); tick(1'b1, 32'hFFFF_FFFF);
    issue(MD_MUL, 32'h1234_5678, 32'd9, 5'd3);            tick(1'b1, 32'hA3D7_0A38);
    idle(4);

    // Signed divide and remainder through the iterative path.
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4); tick(1'b1, 32'hFFFF_FFFD);
    idle(DIV_LAT + 1);
    issue(MD_REM, 32'hFFFF_FFF9, 32'd2, 5'd5); tick(1'b1, 32'hFFFF_FFFF);
    idle(DIV_LAT + 1);

    // Special cases take the multiply slot.
    issue(MD_DIVU, 32'd5, 32'd0, 5'd6);                   tick(1'b1, 32'hFFFF_FFFF);
    issue(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);    tick(1'b1, 32'h0000_0000);
    idle(4);

    // Kill in cycle 5 of a divide; new request the cycle after.
    issue(MD_DIV, 32'd1000, 32'd7, 5'd8); tick();
    idle(4);
    kill = 1'b1; tick();
    kill = 1'b0;
    issue(MD_MUL, 32'd6, 32'd7, 5'd9); tick(1'b1, 32'd42);
    idle(4);

    // Multiply accepted just before kill, a request alongside kill, then one after.
    issue(MD_MUL, 32'd3, 32'd5, 5'd10); tick();
    issue(MD_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd11); kill = 1'b1; tick();
    kill = 1'b0;
    issue(MD_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd12); tick(1'b1, 32'd1);
    idle(4);

    // 64-bit, radix-16 divider latency.
    check("ready64", {63'd0, req_ready64}, 64'd1);
    req_valid64 = 1'b1;
    op64        = MD_DIVU;
    a64         = 64'h8000_0000_0000_0000;
    b64         = 64'd3;
    tag64       = 5'd21;
    start_cyc   = cyc;
    tick();
    req_valid64 = 1'b0;
    check("busy64", {63'd0, busy64}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (rsp_valid64) begin
        seen = 1'b1;
        check("div64_latency", 64'(cyc - start_cyc), 64'd18);
        check("div64_data", rsp_data64, 64'h2AAA_AAAA_AAAA_AAAA);
        check("div64_tag", {59'd0, rsp_tag64}, 64'd21);
        $display("rsp64 cyc=%0d tag=%0d data=%016h", cyc, rsp_tag64, rsp_data64);
      end else begin
        tick();
      end
    end
    check("div64_seen", {63'd0, seen}, 64'd1);
    idle(2);

    // Random mixed stream.
    n_start = n_acc;
    while ((n_acc - n_start) < 10000 && cyc < 80000) begin
      req_valid = ($urandom_range(9) != 0);
      kill      = ($urandom_range(299) == 0);
      if ($urandom_range(99) < 15) op = md_op_t'(4 + $urandom_range(3));
      else                         op = md_op_t'($urandom_range(3));
      rs1     = pick_operand();
      rs2     = pick_operand();
      req_tag = 5'($urandom);
      tick();
    end
    kill = 1'b0;
    check("random_ops", 64'(n_acc - n_start), 64'd10000);
    idle(DIV_LAT + 4);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rv_muldiv_p.md
RV_MULDIV_P -- requirements
Module: rv_muldiv_p

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 32 or 64.
REQ-002 SHALL have parameter DIV_BITS, default 2, quotient bits retired per divide iteration; legal values 1, 2 or 4; XLEN % DIV_BITS == 0.
REQ-003 SHALL have parameter MUL_LAT, default 2, cycles from multiply acceptance to result; legal values 1..3.
REQ-004 SHALL have parameter TAGW, default 5, width of the pass-through destination tag.
REQ-005 SHALL have ports: clk  in  1  sole clock; reset is synchronous and active-high.
REQ-006 SHALL have ports: reset  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: req_valid in 1 request present; req_ready out 1 request accepted when both high; op in md_op_t (3) operation; rs1, rs2 in XLEN operands; req_tag in TAGW tag.
REQ-008 SHALL have ports: kill in 1 flush all in-flight work; busy out 1 divider occupied.
REQ-009 SHALL have ports: rsp_valid out 1 one-cycle result strobe; rsp_data out XLEN result; rsp_tag out TAGW tag of that result.

Function
REQ-010 SHALL accept a request in any cycle with req_valid & req_ready & !kill.
REQ-011 SHALL drive req_ready = (div state == IDLE) & !reset; req_ready is independent of req_valid.
REQ-012 SHALL implement MUL (low XLEN of rs1*rs2), MULH (s*s high), MULHSU (s*u high), MULHU (u*u high), per RISC-V M semantics.
REQ-013 SHALL deliver multiply results exactly MUL_LAT cycles after acceptance; fully pipelined, one multiply per cycle.
REQ-014 SHALL implement DIV, DIVU, REM, REMU with a restoring iterative divider on magnitudes; sign is applied afterwards (quotient negated if rs1/rs2 signs differ, remainder takes rs1 sign).
REQ-015 SHALL run divide states IDLE -> CALC (XLEN/DIV_BITS cycles) -> FIX (1 cycle, sign fix, rsp_valid) -> IDLE; latency XLEN/DIV_BITS + 2 cycles from acceptance.
REQ-016 SHALL assert busy in CALC and FIX.
REQ-017 SHALL treat divide by zero as a special case: DIV/DIVU -> all ones; REM/REMU -> rs1.
REQ-018 SHALL treat signed overflow (rs1 = most-negative, rs2 = -1) as a special case: DIV -> rs1; REM -> 0.
REQ-019 SHALL route special cases through the multiply pipeline slot instead of the divider: result after MUL_LAT cycles, state stays IDLE.
REQ-020 SHALL return results in acceptance order; with the REQ-003 bounds a multiply result can never coincide with a divide result, so no arbitration is needed.
REQ-021 SHALL return the request's req_tag on rsp_tag with the same rsp_valid.
REQ-022 SHALL, on kill, clear all pipeline valids and return the divider to IDLE at the next edge; no rsp_valid in the cycle after kill for any pre-kill request; kill together with req_valid accepts nothing.
REQ-023 SHALL hold rsp_data/rsp_tag stable only while rsp_valid is high; other cycles are don't-care.

Reset
REQ-024 SHALL, on reset, set req_ready=0 during reset, rsp_valid=0, busy=0, div state IDLE, all pipeline valids 0.
REQ-025 SHALL let reset mid-divide abandon the operation with no response; data registers need no reset.

Structure
REQ-026 SHALL place md_op_t (funct3 encoding MUL=0..REMU=7) and the legal-parameter checks in package pkg_rv_muldiv.
REQ-027 SHALL use one sub-module, rv_div_iter, holding the iterative divider (magnitudes in; quotient/remainder plus done out); the multiplier and its pipeline stay in rv_muldiv_p.
REQ-028 SHALL elaborate-time assert REQ-001..REQ-003 legality.

Verification
REQ-029 SHALL check XLEN=32, MUL_LAT=2: MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; back-to-back accepts, results on consecutive cycles.
REQ-030 SHALL check DIV_BITS=2: DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF, rsp_valid exactly 18 cycles after accept, req_ready low throughout.
REQ-031 SHALL check DIVU 5/0 -> 0xFFFFFFFF and REM 0x80000000/-1 -> 0, both MUL_LAT cycles after accept, busy never high.
REQ-032 SHALL check XLEN=64, DIV_BITS=4: DIVU 2^63/3 -> 0x2AAAAAAAAAAAAAAA, latency 18.
REQ-033 SHALL check kill in cycle 5 of a divide, plus a multiply accepted the cycle before kill: no rsp_valid for either; a new request is accepted the cycle after kill.
REQ-034 SHALL check a random mixed stream of 10k operations against a reference model, with tags matched in order.
